// File: rtl/mem_block_copy.sv
// mem_block_copy
//   Block-copy engine that drives the single-cycle, word-addressed port of
//   the 16-bit memory model. A start request copies `len` words from
//   `src_addr` to `dst_addr`, one read then one write per word, with
//   memmove semantics for overlapping regions. A 16-bit additive checksum
//   of the words read is kept and held until the next accepted start.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous reset, active low
//   start       copy request, sampled only in IDLE
//   src_addr    first source word address, latched at start
//   dst_addr    first destination word address, latched at start
//   len         number of words to copy, latched at start (0 is legal)
//   busy        high in READ and WRITE
//   done        one-cycle completion pulse
//   checksum    sum mod 2^DATA_W of the words read by the last copy
//   mem_enable  memory enable
//   mem_wr      memory write strobe
//   mem_addr    memory word address
//   mem_wdata   memory write data
//   mem_rdata   memory read data (combinational read)
//
// States
//   IDLE  | waiting for start, memory port quiet
//   READ  | reading the word at the source pointer
//   WRITE | writing the captured word at the destination pointer
//   DONE  | one-cycle completion pulse

module mem_block_copy #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // One extra bit so src_addr + len cannot overflow in the overlap test.
    localparam int EXT_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] src_ptr_q;
    logic [ADDR_W-1:0] dst_ptr_q;
    logic [LEN_W-1:0]  count_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] checksum_q;
    logic              backward_q;

    logic [EXT_W-1:0]  src_ext;
    logic [EXT_W-1:0]  dst_ext;
    logic [EXT_W-1:0]  len_ext;
    logic [EXT_W-1:0]  src_end;
    logic              start_backward;
    logic [ADDR_W-1:0] len_addr;
    logic [ADDR_W-1:0] src_last;
    logic [ADDR_W-1:0] dst_last;

    assign src_ext = EXT_W'(src_addr);
    assign dst_ext = EXT_W'(dst_addr);
    assign len_ext = EXT_W'(len);
    assign src_end = src_ext + len_ext;

    // Destination starts inside the source region above its base: a forward
    // copy would overwrite source words before they are read, so run
    // backward from the last word instead.
    assign start_backward = (dst_ext > src_ext) && (dst_ext < src_end);

    assign len_addr = ADDR_W'(len);
    assign src_last = src_addr + len_addr - ADDR_W'(1);
    assign dst_last = dst_addr + len_addr - ADDR_W'(1);

    assign checksum = checksum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory port outputs are decoded from registered state and pointers
    // only; start never reaches them combinationally.
    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        done       = 1'b0;
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                busy       = 1'b1;
                mem_enable = 1'b1;
                mem_addr   = src_ptr_q;
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                busy       = 1'b1;
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = dst_ptr_q;
                mem_wdata  = data_q;
                state_d    = (count_q == LEN_W'(1)) ? S_DONE : S_READ;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_ptr_q  <= '0;
            dst_ptr_q  <= '0;
            count_q    <= '0;
            data_q     <= '0;
            checksum_q <= '0;
            backward_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        checksum_q <= '0;
                        count_q    <= len;
                        backward_q <= start_backward;
                        src_ptr_q  <= start_backward ? src_last : src_addr;
                        dst_ptr_q  <= start_backward ? dst_last : dst_addr;
                    end
                end
                S_READ: begin
                    data_q     <= mem_rdata;
                    checksum_q <= checksum_q + mem_rdata;
                    src_ptr_q  <= backward_q ? (src_ptr_q - ADDR_W'(1))
                                             : (src_ptr_q + ADDR_W'(1));
                end
                S_WRITE: begin
                    dst_ptr_q <= backward_q ? (dst_ptr_q - ADDR_W'(1))
                                            : (dst_ptr_q + ADDR_W'(1));
                    count_q   <= count_q - LEN_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_block_copy.sv
module tb_mem_block_copy;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [15:0] checksum;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_block_copy #(.ADDR_W(16), .DATA_W(16), .LEN_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum),
        .mem_enable (mem_enable),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Memory model driven by the DUT, and the reference image of it.
    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_enable && mem_wr) mem[mem_addr] = mem_wdata;
    end

    // Observations of one copy.
    logic [15:0] obs_rd[$];
    logic [15:0] obs_wr[$];
    logic [15:0] obs_wd[$];
    int obs_busy;
    int obs_done_cyc;
    int obs_done_cnt;
    int obs_viol;

    // Reference expectations of one copy.
    logic [15:0] exp_rd[$];
    logic [15:0] exp_wr[$];
    logic [15:0] exp_wd[$];
    logic [15:0] exp_cs;

    task automatic poke(input logic [15:0] a, input logic [15:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    // memmove: read every source word first, then write them all.
    task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int l);
        logic [15:0] tmp[$];
        bit bwd;
        int k;
        exp_rd.delete();
        exp_wr.delete();
        exp_wd.delete();
        exp_cs = 16'h0000;
        for (int i = 0; i < l; i++) tmp.push_back(ref_mem[s + 16'(i)]);
        for (int i = 0; i < l; i++) begin
            ref_mem[d + 16'(i)] = tmp[i];
            exp_cs = exp_cs + tmp[i];
        end
        bwd = (int'(d) > int'(s)) && (int'(d) < int'(s) + l);
        for (int j = 0; j < l; j++) begin
            k = bwd ? (l - 1 - j) : j;
            exp_rd.push_back(s + 16'(k));
            exp_wr.push_back(d + 16'(k));
            exp_wd.push_back(tmp[k]);
        end
    endtask

    function automatic int mem_diffs();
        int n = 0;
        for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) n++;
        return n;
    endfunction

    function automatic int q_diffs(input logic [15:0] a[$], input logic [15:0] b[$]);
        int n;
        n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) n++;
        return n;
    endfunction

    task automatic sample(input int c);
        if (busy) obs_busy++;
        if (done) begin
            if (obs_done_cnt == 0) obs_done_cyc = c;
            obs_done_cnt++;
            if (busy) obs_viol++;
        end
        if (mem_enable && !mem_wr) obs_rd.push_back(mem_addr);
        if (mem_enable && mem_wr) begin
            obs_wr.push_back(mem_addr);
            obs_wd.push_back(mem_wdata);
        end
        if (mem_enable !== busy) obs_viol++;
        if (mem_wr && !mem_enable) obs_viol++;
        if (!mem_enable && (mem_addr !== 16'h0 || mem_wdata !== 16'h0)) obs_viol++;
    endtask

    // Issues one start and watches a fixed 2*l+2 cycles after the start edge.
    // Inputs are scrambled right after the start edge.
    task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input int l);
        obs_rd.delete();
        obs_wr.delete();
        obs_wd.delete();
        obs_busy = 0;
        obs_done_cyc = -1;
        obs_done_cnt = 0;
        obs_viol = 0;
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len = 16'(l);
        start = 1'b1;
        @(posedge clk);
        #1;
        sample(1);
        @(negedge clk);
        start = 1'b0;
        src_addr = 16'($urandom);
        dst_addr = 16'($urandom);
        len = 16'($urandom);
        for (int c = 2; c <= 2 * l + 2; c++) begin
            @(posedge clk);
            #1;
            sample(c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b1;
        src_addr = 16'h0100;
        dst_addr = 16'h0200;
        len = 16'd4;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, mem_enable, mem_wr} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl: busy/done/en/wr=%b required 0000", {busy, done, mem_enable, mem_wr});
        end
        checks++;
        if (checksum !== 16'h0) begin
            failures++;
            $display("FAIL reset_checksum: got %h required 0000", checksum);
        end
        checks++;
        if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
            failures++;
            $display("FAIL reset_mem_bus: addr=%h wdata=%h required 0000/0000", mem_addr, mem_wdata);
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) poke(16'h0100 + 16'(i), 16'(i + 1));
        model_copy(16'h0100, 16'h0200, 4);
        run_copy(16'h0100, 16'h0200, 4);
        checks++;
        if (mem_diffs() != 0) begin
            failures++;
            $display("FAIL basic_mem: %0d words differ, required 0", mem_diffs());
        end
        checks++;
        if (checksum !== 16'h000A) begin
            failures++;
            $display("FAIL basic_checksum: got %h required 000a", checksum);
        end
        checks++;
        if (obs_busy != 8) begin
            failures++;
            $display("FAIL basic_busy_cycles: got %0d required 8", obs_busy);
        end
        checks++;
        if (obs_done_cyc != 9 || obs_done_cnt != 1) begin
            failures++;
            $display("FAIL basic_done: cycle %0d count %0d required cycle 9 count 1", obs_done_cyc, obs_done_cnt);
        end
        checks++;
        if (obs_viol != 0) begin
            failures++;
            $display("FAIL basic_port_rules: %0d violations required 0", obs_viol);
        end
        checks++;
        if (q_diffs(obs_rd, exp_rd) != 0 || q_diffs(obs_wr, exp_wr) != 0) begin
            failures++;
            $display("FAIL basic_addr_seq: %0d/%0d read/write address differences required 0",
                     q_diffs(obs_rd, exp_rd), q_diffs(obs_wr, exp_wr));
        end
    endtask

    task automatic test_backward_overlap();
        poke(16'h0010, 16'hAAAA);
        poke(16'h0011, 16'hBBBB);
        poke(16'h0012, 16'hCCCC);
        poke(16'h0013, 16'hDDDD);
        model_copy(16'h0010, 16'h0012, 4);
        run_copy(16'h0010, 16'h0012, 4);
        checks++;
        if (mem_diffs() != 0 || mem[16'h0015] !== 16'hDDDD || mem[16'h0012] !== 16'hAAAA) begin
            failures++;
            $display("FAIL bwd_mem: %0d words differ, [0012]=%h [0015]=%h required aaaa dddd",
                     mem_diffs(), mem[16'h0012], mem[16'h0015]);
        end
        checks++;
        if (obs_rd.size() == 0 || obs_wr.size() == 0 || obs_rd[0] !== 16'h0013 || obs_wr[0] !== 16'h0015) begin
            failures++;
            $display("FAIL bwd_first_addr: %0d reads %0d writes, required first read 0013 first write 0015",
                     obs_rd.size(), obs_wr.size());
        end
    endtask

    task automatic test_forward_overlap();
        poke(16'h0012, 16'hAAAA);
        poke(16'h0013, 16'hBBBB);
        poke(16'h0014, 16'hCCCC);
        poke(16'h0015, 16'hDDDD);
        model_copy(16'h0012, 16'h0010, 4);
        run_copy(16'h0012, 16'h0010, 4);
        checks++;
        if (mem_diffs() != 0 || mem[16'h0010] !== 16'hAAAA || mem[16'h0013] !== 16'hDDDD) begin
            failures++;
            $display("FAIL fwd_mem: %0d words differ, [0010]=%h [0013]=%h required aaaa dddd",
                     mem_diffs(), mem[16'h0010], mem[16'h0013]);
        end
        checks++;
        if (obs_wr.size() == 0 || obs_wr[0] !== 16'h0010) begin
            failures++;
            $display("FAIL fwd_first_write: %0d writes, required first write 0010", obs_wr.size());
        end
    endtask

    task automatic test_len_zero_and_wrap_sum();
        model_copy(16'h0300, 16'h0400, 0);
        run_copy(16'h0300, 16'h0400, 0);
        checks++;
        if (obs_done_cyc != 1 || obs_done_cnt != 1) begin
            failures++;
            $display("FAIL len0_done: cycle %0d count %0d required cycle 1 count 1", obs_done_cyc, obs_done_cnt);
        end
        checks++;
        if (obs_rd.size() + obs_wr.size() != 0 || obs_viol != 0) begin
            failures++;
            $display("FAIL len0_no_access: %0d accesses %0d violations required 0 0",
                     obs_rd.size() + obs_wr.size(), obs_viol);
        end
        checks++;
        if (checksum !== 16'h0000) begin
            failures++;
            $display("FAIL len0_checksum: got %h required 0000", checksum);
        end
        poke(16'h0500, 16'hFFFF);
        poke(16'h0501, 16'h0002);
        model_copy(16'h0500, 16'h0600, 2);
        run_copy(16'h0500, 16'h0600, 2);
        checks++;
        if (checksum !== 16'h0001 || checksum !== exp_cs) begin
            failures++;
            $display("FAIL sum_wrap_checksum: got %h required 0001", checksum);
        end
    endtask

    task automatic test_addr_wrap();
        logic [15:0] want[$];
        want = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        model_copy(16'hFFFE, 16'h1000, 4);
        run_copy(16'hFFFE, 16'h1000, 4);
        checks++;
        if (q_diffs(obs_rd, want) != 0) begin
            failures++;
            $display("FAIL wrap_read_seq: %0d differences (%0d reads), required fffe ffff 0000 0001",
                     q_diffs(obs_rd, want), obs_rd.size());
        end
        checks++;
        if (mem_diffs() != 0 || checksum !== exp_cs) begin
            failures++;
            $display("FAIL wrap_result: %0d words differ, checksum %h required %h", mem_diffs(), checksum, exp_cs);
        end
    endtask

    task automatic test_random();
        logic [15:0] s;
        logic [15:0] d;
        int l;
        for (int it = 0; it < 20; it++) begin
            s = 16'($urandom);
            if (it % 4 == 0) d = 16'($urandom);
            else d = s + 16'($urandom_range(0, 24)) - 16'd12;
            l = $urandom_range(0, 12);
            model_copy(s, d, l);
            run_copy(s, d, l);
            checks++;
            if (mem_diffs() != 0) begin
                failures++;
                $display("FAIL rand_mem it=%0d src=%h dst=%h len=%0d: %0d words differ", it, s, d, l, mem_diffs());
            end
            checks++;
            if (checksum !== exp_cs) begin
                failures++;
                $display("FAIL rand_checksum it=%0d: got %h required %h", it, checksum, exp_cs);
            end
            checks++;
            if (obs_done_cyc != 2 * l + 1 || obs_done_cnt != 1 || obs_busy != 2 * l) begin
                failures++;
                $display("FAIL rand_timing it=%0d: done cycle %0d count %0d busy %0d required %0d 1 %0d",
                         it, obs_done_cyc, obs_done_cnt, obs_busy, 2 * l + 1, 2 * l);
            end
            checks++;
            if (q_diffs(obs_rd, exp_rd) != 0 || q_diffs(obs_wr, exp_wr) != 0 ||
                q_diffs(obs_wd, exp_wd) != 0 || obs_viol != 0) begin
                failures++;
                $display("FAIL rand_port it=%0d: rd/wr/wd diffs %0d/%0d/%0d violations %0d required 0",
                         it, q_diffs(obs_rd, exp_rd), q_diffs(obs_wr, exp_wr), q_diffs(obs_wd, exp_wd), obs_viol);
            end
        end
    endtask

    task automatic test_back_to_back();
        int seen_done = 0;
        int done2 = -1;
        @(negedge clk);
        src_addr = 16'h6000;
        dst_addr = 16'h6100;
        len = 16'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        src_addr = 16'h6200;
        dst_addr = 16'h6300;
        len = 16'd3;
        for (int c = 2; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 5 && done === 1'b1) seen_done = 1;
            if (c == 6) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || seen_done != 1) begin
                    failures++;
                    $display("FAIL b2b_first: done seen %0d, idle busy=%b done=%b required 1 0 0", seen_done, busy, done);
                end
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || mem_addr !== 16'h6200 || mem_wr !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart: busy=%b addr=%h wr=%b required 1 6200 0", busy, mem_addr, mem_wr);
        end
        @(negedge clk);
        start = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 && done2 < 0) done2 = c;
        end
        model_copy(16'h6000, 16'h6100, 2);
        model_copy(16'h6200, 16'h6300, 3);
        checks++;
        if (done2 != 7 || mem_diffs() != 0 || checksum !== exp_cs) begin
            failures++;
            $display("FAIL b2b_second: done cycle %0d, %0d words differ, checksum %h required 7 0 %h",
                     done2, mem_diffs(), checksum, exp_cs);
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        src_addr = 16'h3000;
        dst_addr = 16'h4000;
        len = 16'd8;
        start = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b1;
        src_addr = 16'h5000;
        len = 16'd3;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h4001) begin
            failures++;
            $display("FAIL abort_ignore_start_c4: busy=%b wr=%b addr=%h required 1 1 4001", busy, mem_wr, mem_addr);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (mem_wr !== 1'b0 || mem_addr !== 16'h3002) begin
            failures++;
            $display("FAIL abort_ignore_start_c5: wr=%b addr=%h required 0 3002", mem_wr, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, mem_enable, mem_wr, mem_addr, mem_wdata, checksum} !== 52'h0) begin
            failures++;
            $display("FAIL abort_outputs_zero: busy=%b done=%b en=%b wr=%b addr=%h wdata=%h cs=%h required all 0",
                     busy, done, mem_enable, mem_wr, mem_addr, mem_wdata, checksum);
        end
        repeat (3) @(posedge clk);
        ref_mem[16'h4000] = ref_mem[16'h3000];
        ref_mem[16'h4001] = ref_mem[16'h3001];
        checks++;
        if (mem_diffs() != 0) begin
            failures++;
            $display("FAIL abort_two_words: %0d words differ from two-word partial copy, required 0", mem_diffs());
        end
        @(negedge clk);
        rst = 1'b1;
        model_copy(16'h3000, 16'h4100, 3);
        run_copy(16'h3000, 16'h4100, 3);
        checks++;
        if (mem_diffs() != 0 || checksum !== exp_cs || obs_done_cyc != 7) begin
            failures++;
            $display("FAIL abort_recover: %0d words differ, checksum %h done cycle %0d required 0 %h 7",
                     mem_diffs(), checksum, obs_done_cyc, exp_cs);
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        src_addr = 16'h0;
        dst_addr = 16'h0;
        len = 16'h0;
        for (int a = 0; a < 65536; a++) begin
            mem[a] = 16'($urandom);
            ref_mem[a] = mem[a];
        end
        test_reset();
        test_basic();
        test_backward_overlap();
        test_forward_overlap();
        test_len_zero_and_wrap_sum();
        test_addr_wrap();
        test_random();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
